// File: rtl/dram_port_arbiter_if.sv
// Bus bundle between the CPU-side requesters (instruction fetch and load/store)
// and the DRAM port arbiter, including the array address/write-enable side.
// The array data bus itself is tristate and stays a plain inout on the arbiter.

`ifndef DRAM_ADDRESS_SIZE
`define DRAM_ADDRESS_SIZE 16
`endif
`ifndef DRAM_WORD_SIZE
`define DRAM_WORD_SIZE 32
`endif

interface dram_port_arbiter_if #(
   parameter int ADDR_W = `DRAM_ADDRESS_SIZE,
   parameter int WORD_W = `DRAM_WORD_SIZE
);
   // Instruction-fetch port (read only)
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_ack;
   logic [WORD_W-1:0] i_rdata;

   // Load/store port
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [WORD_W-1:0] d_wdata;
   logic              d_ack;
   logic [WORD_W-1:0] d_rdata;

   // Array control side and status
   logic [ADDR_W-1:0] mem_address;
   logic              mem_wren;
   logic              busy;

   // The arbiter serves both requesters and drives the array controls
   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
      output i_ack, i_rdata, d_ack, d_rdata, mem_address, mem_wren, busy
   );

   // The requester / environment side
   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
      input  i_ack, i_rdata, d_ack, d_rdata, mem_address, mem_wren, busy
   );
endinterface

// File: rtl/dram_port_arbiter.sv
// DRAM port arbiter: shares one single-ported, byte-addressed, big-endian DRAM
// array between the instruction-fetch port and the load/store port. One transfer
// at a time, IDLE -> ACCESS (LATENCY cycles) -> DONE, with alternating priority
// when both ports are waiting so neither can starve the other.

`ifndef DRAM_ADDRESS_SIZE
`define DRAM_ADDRESS_SIZE 16
`endif
`ifndef DRAM_WORD_SIZE
`define DRAM_WORD_SIZE 32
`endif

module dram_port_arbiter #(
   parameter int ADDR_W  = `DRAM_ADDRESS_SIZE,
   parameter int WORD_W  = `DRAM_WORD_SIZE,
   parameter int LATENCY = 2
) (
   input  logic               clock,
   input  logic               reset,
   dram_port_arbiter_if.slave bus,
   inout  wire [WORD_W-1:0]   mem_data
);

   // Counter only needs to hold LATENCY-1; keep at least one bit for LATENCY=1
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   // A zero-cycle access or a non-32-bit word makes no sense for this array
   generate
      if (LATENCY < 1 || WORD_W != 32) begin : g_badParams
         $error("dram_port_arbiter: LATENCY must be >= 1 and WORD_W must be 32");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_t;

   state_t            r_state;
   state_t            w_nextState;
   logic              w_grant;
   logic              w_pickD;
   logic              w_lastAccess;
   logic              w_memWren;

   logic              r_grantD;
   logic              r_lastGrantD;
   logic              r_we;
   logic [ADDR_W-1:0] r_memAddress;
   logic [WORD_W-1:0] r_wdata;
   logic [CNT_W-1:0]  r_cnt;
   logic [WORD_W-1:0] r_iRdata;
   logic [WORD_W-1:0] r_dRdata;

   // The final ACCESS cycle is where a write is driven onto the array and where
   // read data is sampled on the closing edge.
   assign w_lastAccess = (r_state == ACCESS) && (r_cnt == '0);
   assign w_memWren    = w_lastAccess && r_we;

   // The array only ever sees our drive while wren is high, so a read from the
   // array can never fight with us, and an abandoned write never reaches it.
   assign mem_data = w_memWren ? r_wdata : {WORD_W{1'bz}};

   assign bus.mem_address = r_memAddress;
   assign bus.mem_wren    = w_memWren;
   assign bus.busy        = (r_state != IDLE);
   assign bus.i_ack       = (r_state == DONE) && !r_grantD;
   assign bus.d_ack       = (r_state == DONE) &&  r_grantD;
   assign bus.i_rdata     = r_iRdata;
   assign bus.d_rdata     = r_dRdata;

   // State register; reset abandons whatever transfer was in flight, and the
   // requester is expected to reissue it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and arbitration. Grants are only taken in IDLE: in DONE the
   // acknowledged requester still shows req high, so granting there would
   // re-serve a request that has already completed. With both ports waiting,
   // the one that was not served last wins.
   always_comb begin
      w_nextState = r_state;
      w_grant     = 1'b0;
      w_pickD     = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.i_req || bus.d_req) begin
               w_grant     = 1'b1;
               w_pickD     = bus.d_req && (!bus.i_req || !r_lastGrantD);
               w_nextState = ACCESS;
            end
         end
         ACCESS: begin
            if (r_cnt == '0) begin
               w_nextState = DONE;
            end
         end
         DONE: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Transfer context: on a grant latch who won, the address, the direction and
   // the write data so the requester's inputs are not needed again; then count
   // down the access latency. The I port is read-only, so its grants never
   // carry a write.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_grantD     <= 1'b0;
         r_lastGrantD <= 1'b0;
         r_we         <= 1'b0;
         r_memAddress <= '0;
         r_wdata      <= '0;
         r_cnt        <= '0;
      end else begin
         if (w_grant) begin
            r_grantD     <= w_pickD;
            r_lastGrantD <= w_pickD;
            r_we         <= w_pickD && bus.d_we;
            r_memAddress <= w_pickD ? bus.d_addr : bus.i_addr;
            r_wdata      <= bus.d_wdata;
            r_cnt        <= CNT_W'(LATENCY - 1);
         end else if ((r_state == ACCESS) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end

   // Read data capture: the array's output is taken on the edge closing the
   // final ACCESS cycle and held in the winning port's register until that
   // port's next read, so a requester can pick it up any time after its ack.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_iRdata <= '0;
         r_dRdata <= '0;
      end else if (w_lastAccess && !r_we) begin
         if (r_grantD) begin
            r_dRdata <= mem_data;
         end else begin
            r_iRdata <= mem_data;
         end
      end
   end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Self-checking bench for dram_port_arbiter: a byte-wide big-endian array model
// around a LATENCY=2 instance driven from a vector table plus hand-written
// sequences (contention, late request, reset mid-write), and two extra
// instances at LATENCY=1 and LATENCY=5 for ack timing.

module tb_dram_port_arbiter;

   localparam int AW = 8;
   localparam int WW = 32;

   logic clock;
   logic reset;
   logic preload;
   logic monitorOn;
   int   checks   = 0;
   int   failures = 0;

   // Free-running 10 ns clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Main instance, LATENCY=2, with a full array model
   dram_port_arbiter_if #(.ADDR_W(AW), .WORD_W(WW)) bus ();
   wire [WW-1:0] memData;

   dram_port_arbiter #(.ADDR_W(AW), .WORD_W(WW), .LATENCY(2)) dut (
      .clock    (clock),
      .reset    (reset),
      .bus      (bus),
      .mem_data (memData)
   );

   // Latency sweep instances; their "array" returns a fixed tag word on reads
   dram_port_arbiter_if #(.ADDR_W(AW), .WORD_W(WW)) busL1 ();
   dram_port_arbiter_if #(.ADDR_W(AW), .WORD_W(WW)) busL5 ();
   wire [WW-1:0] memDataL1;
   wire [WW-1:0] memDataL5;
   assign memDataL1 = busL1.mem_wren ? 'z : 32'hA5A5_0001;
   assign memDataL5 = busL5.mem_wren ? 'z : 32'hA5A5_0005;

   dram_port_arbiter #(.ADDR_W(AW), .WORD_W(WW), .LATENCY(1)) dutL1 (
      .clock    (clock),
      .reset    (reset),
      .bus      (busL1),
      .mem_data (memDataL1)
   );

   dram_port_arbiter #(.ADDR_W(AW), .WORD_W(WW), .LATENCY(5)) dutL5 (
      .clock    (clock),
      .reset    (reset),
      .bus      (busL5),
      .mem_data (memDataL5)
   );

   // Byte-addressed big-endian array: it drives the word at mem_address whenever
   // the arbiter is not writing, exactly like the real array's read drive
   logic [7:0]    mem [0:255];
   logic [WW-1:0] arrayWord;

   always_comb begin
      arrayWord = {mem[bus.mem_address], mem[bus.mem_address + 8'd1],
                   mem[bus.mem_address + 8'd2], mem[bus.mem_address + 8'd3]};
   end

   assign memData = bus.mem_wren ? 'z : arrayWord;

   // Array storage: one-time preload, then byte writes (MSB at the lowest
   // address) on every edge where wren is high, and only then
   always @(posedge clock) begin
      if (preload) begin
         for (int k = 0; k < 256; k++) mem[k] <= 8'h00;
         mem[8'h10] <= 8'hDE; mem[8'h11] <= 8'hAD; mem[8'h12] <= 8'hBE; mem[8'h13] <= 8'hEF;
         mem[8'h40] <= 8'h11; mem[8'h41] <= 8'h22; mem[8'h42] <= 8'h33; mem[8'h43] <= 8'h44;
      end else if (bus.mem_wren) begin
         mem[bus.mem_address]         <= memData[31:24];
         mem[bus.mem_address + 8'd1]  <= memData[23:16];
         mem[bus.mem_address + 8'd2]  <= memData[15:8];
         mem[bus.mem_address + 8'd3]  <= memData[7:0];
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Bus watcher: while writing, the bus must carry the requested write data;
   // otherwise only the array may drive it, so it must show the array's word
   always @(negedge clock) begin
      if (monitorOn) begin
         if (bus.mem_wren) checkOutput("busWriteDrive", memData, bus.d_wdata);
         else              checkOutput("busReleased", memData, arrayWord);
      end
   end

   typedef struct {
      logic        isD;
      logic        we;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [31:0] expRdata;
      int          expLat;
   } vec_t;

   vec_t vecs[9];

   // One single-port transfer on the LATENCY=2 instance: raise req, count
   // falling edges until ack (bounded), then drop req
   task automatic applyStimulus(input vec_t vc, output int lat, output int wrenCycles,
                                output int otherAcks);
      bit gotAck;
      @(negedge clock);
      if (vc.isD) begin
         bus.d_req   = 1'b1;
         bus.d_we    = vc.we;
         bus.d_addr  = vc.addr;
         bus.d_wdata = vc.wdata;
      end else begin
         bus.i_req  = 1'b1;
         bus.i_addr = vc.addr;
      end
      lat        = 0;
      wrenCycles = 0;
      otherAcks  = 0;
      gotAck     = 1'b0;
      while (!gotAck && lat < 20) begin
         @(negedge clock);
         lat++;
         if (bus.mem_wren) wrenCycles++;
         if (vc.isD ? bus.i_ack : bus.d_ack) otherAcks++;
         if (vc.isD ? bus.d_ack : bus.i_ack) gotAck = 1'b1;
      end
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
   endtask

   // Main test sequence
   initial begin
      int lat, wrenCycles, otherAcks;
      int n, ackIdx, lastAck, iAt, dAt, l1At, l5At, l1Wren, l5Wren;
      logic [31:0] word;

      reset     = 1'b1;
      preload   = 1'b1;
      monitorOn = 1'b0;
      bus.i_req = 1'b0; bus.i_addr = '0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
      busL1.i_req = 1'b0; busL1.i_addr = '0;
      busL1.d_req = 1'b0; busL1.d_we = 1'b0; busL1.d_addr = '0; busL1.d_wdata = '0;
      busL5.i_req = 1'b0; busL5.i_addr = '0;
      busL5.d_req = 1'b0; busL5.d_we = 1'b0; busL5.d_addr = '0; busL5.d_wdata = '0;

      vecs[0] = '{1'b0, 1'b0, 8'h10, 32'h0,         32'hDEADBEEF, 3};
      vecs[1] = '{1'b1, 1'b1, 8'h20, 32'h12345678,  32'h0,        3};
      vecs[2] = '{1'b1, 1'b0, 8'h20, 32'h0,         32'h12345678, 3};
      vecs[3] = '{1'b0, 1'b0, 8'h20, 32'h0,         32'h12345678, 3};
      vecs[4] = '{1'b1, 1'b1, 8'h30, 32'hA1B2C3D4,  32'h0,        3};
      vecs[5] = '{1'b0, 1'b0, 8'h30, 32'h0,         32'hA1B2C3D4, 3};
      vecs[6] = '{1'b1, 1'b0, 8'h10, 32'h0,         32'hDEADBEEF, 3};
      vecs[7] = '{1'b1, 1'b0, 8'h31, 32'h0,         32'hB2C3D400, 3};
      vecs[8] = '{1'b0, 1'b0, 8'h40, 32'h0,         32'h11223344, 3};

      @(posedge clock);
      @(negedge clock);
      preload = 1'b0;
      checkOutput("rstIAck",    bus.i_ack,       0);
      checkOutput("rstDAck",    bus.d_ack,       0);
      checkOutput("rstWren",    bus.mem_wren,    0);
      checkOutput("rstBusy",    bus.busy,        0);
      checkOutput("rstAddr",    bus.mem_address, 0);
      checkOutput("rstIRdata",  bus.i_rdata,     0);
      checkOutput("rstDRdata",  bus.d_rdata,     0);
      reset     = 1'b0;
      monitorOn = 1'b1;

      $display("[TB] vector table");
      for (int v = 0; v < 9; v++) begin
         applyStimulus(vecs[v], lat, wrenCycles, otherAcks);
         checkOutput($sformatf("v%0d ackLatency", v), lat, vecs[v].expLat);
         checkOutput($sformatf("v%0d wrenCycles", v), wrenCycles, (vecs[v].isD && vecs[v].we) ? 1 : 0);
         checkOutput($sformatf("v%0d otherAck", v), otherAcks, 0);
         checkOutput($sformatf("v%0d memAddress", v), bus.mem_address, vecs[v].addr);
         if (vecs[v].isD && vecs[v].we) begin
            word = {mem[vecs[v].addr], mem[vecs[v].addr + 8'd1],
                    mem[vecs[v].addr + 8'd2], mem[vecs[v].addr + 8'd3]};
            checkOutput($sformatf("v%0d arrayBytes", v), word, vecs[v].wdata);
         end else begin
            checkOutput($sformatf("v%0d rdata", v), vecs[v].isD ? bus.d_rdata : bus.i_rdata,
                        vecs[v].expRdata);
         end
         @(negedge clock);
         checkOutput($sformatf("v%0d busyAfter", v), bus.busy, 0);
      end

      // Continuous contention straight after reset: D first, then alternate
      $display("[TB] contention");
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      bus.i_addr = 8'h10;
      bus.d_addr = 8'h20;
      bus.d_we   = 1'b0;
      bus.i_req  = 1'b1;
      bus.d_req  = 1'b1;
      n = 0; ackIdx = 0; lastAck = 0;
      while (ackIdx < 4 && n < 40) begin
         @(negedge clock);
         n++;
         if (bus.i_ack || bus.d_ack) begin
            checkOutput($sformatf("contend%0d port", ackIdx), {bus.d_ack, bus.i_ack},
                        (ackIdx % 2 == 0) ? 2'b10 : 2'b01);
            checkOutput($sformatf("contend%0d spacing", ackIdx), n - lastAck,
                        (ackIdx == 0) ? 3 : 4);
            if (bus.d_ack) checkOutput($sformatf("contend%0d dRdata", ackIdx), bus.d_rdata, 32'h12345678);
            else           checkOutput($sformatf("contend%0d iRdata", ackIdx), bus.i_rdata, 32'hDEADBEEF);
            lastAck = n;
            ackIdx++;
         end
      end
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
      checkOutput("contendAckCount", ackIdx, 4);
      @(negedge clock);

      // D request arriving while I is already in ACCESS waits for the next IDLE
      $display("[TB] late D request");
      @(negedge clock);
      bus.i_addr = 8'h30;
      bus.i_req  = 1'b1;
      @(negedge clock);
      n = 1;
      bus.d_addr = 8'h10;
      bus.d_we   = 1'b0;
      bus.d_req  = 1'b1;
      iAt = -1; dAt = -1;
      while ((iAt < 0 || dAt < 0) && n < 30) begin
         @(negedge clock);
         n++;
         if (bus.i_ack) begin iAt = n; bus.i_req = 1'b0; end
         if (bus.d_ack) begin dAt = n; bus.d_req = 1'b0; end
      end
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
      checkOutput("lateIAckAt", iAt, 3);
      checkOutput("lateDAfterI", dAt - iAt, 4);
      checkOutput("lateIRdata", bus.i_rdata, 32'hA1B2C3D4);
      checkOutput("lateDRdata", bus.d_rdata, 32'hDEADBEEF);

      // Reset during the final ACCESS cycle of a write: nothing may land
      $display("[TB] reset mid-write");
      @(negedge clock);
      bus.d_we    = 1'b1;
      bus.d_addr  = 8'h40;
      bus.d_wdata = 32'hCAFEF00D;
      bus.d_req   = 1'b1;
      @(negedge clock);
      @(negedge clock);
      checkOutput("midWrWrenBefore", bus.mem_wren, 1);
      #2;
      reset     = 1'b1;
      bus.d_req = 1'b0;
      #1;
      checkOutput("midWrWren",   bus.mem_wren,    0);
      checkOutput("midWrBusy",   bus.busy,        0);
      checkOutput("midWrDAck",   bus.d_ack,       0);
      checkOutput("midWrAddr",   bus.mem_address, 0);
      checkOutput("midWrBus",    memData,         32'h0);
      checkOutput("midWrIRdata", bus.i_rdata,     0);
      checkOutput("midWrDRdata", bus.d_rdata,     0);
      @(negedge clock);
      reset = 1'b0;
      n = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         if (bus.d_ack || bus.i_ack) n++;
      end
      checkOutput("midWrNoAck", n, 0);
      word = {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]};
      checkOutput("midWrArrayUnchanged", word, 32'h11223344);

      // Latency sweep: ack exactly LATENCY+1 cycles after the request
      $display("[TB] latency sweep");
      @(negedge clock);
      busL1.i_req = 1'b1;
      busL5.i_req = 1'b1;
      n = 0; l1At = -1; l5At = -1;
      while ((l1At < 0 || l5At < 0) && n < 20) begin
         @(negedge clock);
         n++;
         if (busL1.i_ack) begin l1At = n; busL1.i_req = 1'b0; end
         if (busL5.i_ack) begin l5At = n; busL5.i_req = 1'b0; end
      end
      busL1.i_req = 1'b0;
      busL5.i_req = 1'b0;
      checkOutput("sweepL1ReadAt",  l1At, 2);
      checkOutput("sweepL5ReadAt",  l5At, 6);
      checkOutput("sweepL1IRdata", busL1.i_rdata, 32'hA5A50001);
      checkOutput("sweepL5IRdata", busL5.i_rdata, 32'hA5A50005);

      @(negedge clock);
      busL1.d_we = 1'b1; busL1.d_addr = 8'h08; busL1.d_wdata = 32'h0BADF00D; busL1.d_req = 1'b1;
      busL5.d_we = 1'b1; busL5.d_addr = 8'h08; busL5.d_wdata = 32'h0BADF00D; busL5.d_req = 1'b1;
      n = 0; l1At = -1; l5At = -1; l1Wren = 0; l5Wren = 0;
      while ((l1At < 0 || l5At < 0) && n < 20) begin
         @(negedge clock);
         n++;
         if (busL1.mem_wren) begin
            l1Wren++;
            checkOutput("sweepL1BusDrive", memDataL1, 32'h0BADF00D);
         end
         if (busL5.mem_wren) begin
            l5Wren++;
            checkOutput("sweepL5BusDrive", memDataL5, 32'h0BADF00D);
         end
         if (busL1.d_ack) begin l1At = n; busL1.d_req = 1'b0; end
         if (busL5.d_ack) begin l5At = n; busL5.d_req = 1'b0; end
      end
      busL1.d_req = 1'b0;
      busL5.d_req = 1'b0;
      checkOutput("sweepL1WriteAt", l1At, 2);
      checkOutput("sweepL5WriteAt", l5At, 6);
      checkOutput("sweepL1WrenCycles", l1Wren, 1);
      checkOutput("sweepL5WrenCycles", l5Wren, 1);

      @(negedge clock);
      monitorOn = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
